// File: rtl/uart_word_loader.sv
// uart_word_loader
//   Receive-side UART front end. Deserialises 8N1 bytes from rx and packs
//   16 consecutive bytes little-endian into a 128-bit word. Each completed
//   word is presented as a one-cycle uart_en strobe with uart_value and
//   uart_addr, which then hold until the next strobe.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   rx         UART serial input, idle high, asynchronous to clk
//   addr_clr   synchronous clear of word address, lane pointer, partial word
//   uart_en    one-cycle word-valid strobe
//   uart_value assembled 128-bit word (byte lane 0 in [7:0])
//   uart_addr  word address of the current strobe
//   frame_err  one-cycle pulse on a bad stop bit
//   busy       high while a frame is in progress
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line idle, waiting for a synchronised 1->0 edge
// S_START | waiting half a bit to re-check the start bit (glitch filter)
// S_DATA  | sampling 8 data bits LSB first, one per bit period
// S_STOP  | waiting one bit period, then checking the stop bit

module uart_word_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              addr_clr,
  output logic              uart_en,
  output logic [127:0]      uart_value,
  output logic [ADDR_W-1:0] uart_addr,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t              state_q, state_d;
  logic                rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic [3:0]          lane_q, lane_d;
  logic [127:0]        word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                en_q, en_d;
  logic [127:0]        value_q, value_d;
  logic [ADDR_W-1:0]   addr_out_q, addr_out_d;
  logic                ferr_q, ferr_d;
  logic                accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      lane_q     <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      en_q       <= 1'b0;
      value_q    <= '0;
      addr_out_q <= '0;
      ferr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      lane_q     <= lane_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      en_q       <= en_d;
      value_q    <= value_d;
      addr_out_q <= addr_out_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    lane_d     = lane_q;
    word_d     = word_q;
    addr_d     = addr_q;
    en_d       = 1'b0;
    value_d    = value_q;
    addr_out_d = addr_out_q;
    ferr_d     = 1'b0;
    accept     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Edge rather than level: a line left low after a bad stop bit
        // must go high again before another frame can start.
        if (rx_prev_q && !rx_sync_q) begin
          state_d = S_START;
          cnt_d   = HALF_LOAD;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!rx_sync_q) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
            cnt_d   = FULL_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          // Back to idle at mid stop bit so a following start edge is caught.
          state_d = S_IDLE;
          if (rx_sync_q) accept = 1'b1;
          else           ferr_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      word_d[{lane_q, 3'b000} +: 8] = shift_q;
      lane_d = lane_q + 4'd1;
      if (lane_q == 4'd15) begin
        en_d       = 1'b1;
        value_d    = word_d;
        addr_out_d = addr_q;
        addr_d     = addr_q + 1'b1;
      end
    end

    // Clear wins over the increment; a coincident strobe keeps the old address.
    if (addr_clr) begin
      addr_d = '0;
      lane_d = '0;
      word_d = '0;
    end
  end

  assign uart_en    = en_q;
  assign uart_value = value_q;
  assign uart_addr  = addr_out_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != S_IDLE);

endmodule
